instr_pair_queue: RTL and testbench

Dual-issue instruction queue that sits between fetch and the dependency relayer. Buffers fetched 16-bit instructions, presents the two oldest as an ordered candidate pair every cycle, and retires one or two entries per cycle according to the relayer's single-issue verdict. When the relayer splits a pair, the second instruction stays in the queue and becomes the oldest instruction of the next pair.

---
 rtl/instr_pair_queue_pkg.sv | 42 ++++
 rtl/instr_pair_queue.sv | 119 +++++++++++
 tb/tb_instr_pair_queue.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/instr_pair_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_pair_queue_pkg
// Purpose  : Shared constants for the instruction pair queue and the
//            dependency relayer: instruction width, NOP encoding and the
//            instruction field positions both blocks decode.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package instr_pair_queue_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Field positions shared with the relayer.
  localparam int DEST_MSB = 10;
  localparam int DEST_LSB = 8;
  localparam int SRC1_MSB = 7;
  localparam int SRC1_LSB = 5;
  localparam int SRC2_MSB = 4;
  localparam int SRC2_LSB = 2;
  localparam int IMM_BIT  = 11;

  function automatic logic [2:0] get_dest(input logic [INSTR_W-1:0] instr);
    return instr[DEST_MSB:DEST_LSB];
  endfunction

  function automatic logic [2:0] get_src1(input logic [INSTR_W-1:0] instr);
    return instr[SRC1_MSB:SRC1_LSB];
  endfunction

  function automatic logic [2:0] get_src2(input logic [INSTR_W-1:0] instr);
    return instr[SRC2_MSB:SRC2_LSB];
  endfunction

  function automatic logic is_imm(input logic [INSTR_W-1:0] instr);
    return instr[IMM_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_pair_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_pair_queue
// Purpose  : Dual-issue instruction queue between fetch and the dependency
//            relayer. Buffers fetched instructions, presents the two oldest
//            as an ordered pair, and retires one or two per cycle according
//            to the relayer's single-issue verdict.
// Ports    : clk, rst_n (async, active-low), flush
//            wr_valid/wr_two/wr_instr0/wr_instr1 -> fetch push (wr_ready out)
//            instr1/instr2/head_valid/pair_valid -> candidate pair out
//            issingleinstr/advance               -> retire control in
// Revision : 1.0 - initial release
// ============================================================================
module instr_pair_queue
  import instr_pair_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_valid,
  input  logic          wr_two,
  input  logic [IW-1:0] wr_instr0,
  input  logic [IW-1:0] wr_instr1,
  output logic          wr_ready,
  output logic [IW-1:0] instr1,
  output logic [IW-1:0] instr2,
  output logic          head_valid,
  output logic          pair_valid,
  input  logic          issingleinstr,
  input  logic          advance
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [IW-1:0] NOP = IW'(NOP_INSTR);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push_en;
  logic [CW-1:0] push_amt;
  logic [CW-1:0] pop_amt;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW-1:0] rd_ptr_p1;

  // Pointers are log2(DEPTH) wide, so +1 wraps modulo DEPTH for free.
  assign wr_ptr_p1 = wr_ptr_q + PW'(1);
  assign rd_ptr_p1 = rd_ptr_q + PW'(1);

  // All outputs depend on registered state only.
  assign head_valid = (count_q != '0);
  assign pair_valid = (count_q >= CW'(2));
  // Ready needs room for a full pair, so a push can never overflow even
  // if nothing pops in the same cycle.
  assign wr_ready   = (count_q <= CW'(DEPTH - 2));

  assign instr1 = head_valid ? mem_q[rd_ptr_q]  : NOP;
  assign instr2 = pair_valid ? mem_q[rd_ptr_p1] : NOP;

  assign push_en  = wr_valid && wr_ready;
  assign push_amt = push_en ? (wr_two ? CW'(2) : CW'(1)) : '0;

  // A pair issues only when two entries exist and the relayer did not
  // split them; with one entry, or a split, only the head retires.
  always_comb begin
    pop_amt = '0;
    if (advance && head_valid) begin
      pop_amt = (pair_valid && !issingleinstr) ? CW'(2) : CW'(1);
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = wr_instr0;
        if (wr_two) begin
          mem_d[wr_ptr_p1] = wr_instr1;
        end
      end
      wr_ptr_d = wr_ptr_q + PW'(push_amt);
      rd_ptr_d = rd_ptr_q + PW'(pop_amt);
      count_d  = count_q + push_amt - pop_amt;
    end
  end

  // Storage is intentionally not reset; outputs are gated by count instead.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_pair_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_pair_queue
// Purpose  : Self-checking bench for instr_pair_queue (DEPTH=8, IW=16).
//            Table of per-cycle stimulus records with expected outputs after
//            the clock edge, plus hand-written reset sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_pair_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        wr_valid;
  logic        wr_two;
  logic [15:0] wr_instr0;
  logic [15:0] wr_instr1;
  logic        wr_ready;
  logic [15:0] instr1;
  logic [15:0] instr2;
  logic        head_valid;
  logic        pair_valid;
  logic        issingleinstr;
  logic        advance;

  int checks = 0;
  int errors = 0;

  instr_pair_queue #(.DEPTH(8), .IW(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .wr_valid      (wr_valid),
    .wr_two        (wr_two),
    .wr_instr0     (wr_instr0),
    .wr_instr1     (wr_instr1),
    .wr_ready      (wr_ready),
    .instr1        (instr1),
    .instr2        (instr2),
    .head_valid    (head_valid),
    .pair_valid    (pair_valid),
    .issingleinstr (issingleinstr),
    .advance       (advance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        wv;
    logic        two;
    logic [15:0] i0;
    logic [15:0] i1;
    logic        adv;
    logic        single;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        eh;
    logic        ep;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e1, input logic [15:0] e2,
                         input logic eh, input logic ep, input logic er);
    chk({tag, " instr1"},     instr1,             e1);
    chk({tag, " instr2"},     instr2,             e2);
    chk({tag, " head_valid"}, {15'd0, head_valid}, {15'd0, eh});
    chk({tag, " pair_valid"}, {15'd0, pair_valid}, {15'd0, ep});
    chk({tag, " wr_ready"},   {15'd0, wr_ready},   {15'd0, er});
  endtask

  task automatic idle_inputs();
    flush = 0; wr_valid = 0; wr_two = 0; wr_instr0 = '0; wr_instr1 = '0;
    advance = 0; issingleinstr = 0;
  endtask

  // One clocked cycle of a push (no pop), driven from the negedge.
  task automatic push_cycle(input logic two, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    idle_inputs();
    wr_valid = 1; wr_two = two; wr_instr0 = a; wr_instr1 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic fl, input logic wv, input logic two,
                      input logic [15:0] i0, input logic [15:0] i1,
                      input logic adv, input logic single,
                      input logic [15:0] e1, input logic [15:0] e2,
                      input logic eh, input logic ep, input logic er);
    vecs.push_back('{fl, wv, two, i0, i1, adv, single, e1, e2, eh, ep, er});
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;

    //    fl wv two i0        i1        adv sgl  exp1      exp2      h  p  r
    // First pair and fall-through.
    addv(0, 1, 1, 16'h1111, 16'h2222, 0, 0, 16'h1111, 16'h2222, 1, 1, 1);
    addv(0, 1, 0, 16'h3333, 16'h0000, 0, 0, 16'h1111, 16'h2222, 1, 1, 1);
    // Split pair: old instr2 becomes instr1.
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h2222, 16'h3333, 1, 1, 1);
    addv(0, 1, 0, 16'h4444, 16'h0000, 0, 0, 16'h2222, 16'h3333, 1, 1, 1);
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h4444, 16'h0000, 1, 0, 1);
    // Count 1, dual verdict: only one pops.
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    // Advance on empty queue is ignored.
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    // Count 3 push-two/pop-two.
    addv(0, 1, 1, 16'h0A01, 16'h0A02, 0, 0, 16'h0A01, 16'h0A02, 1, 1, 1);
    addv(0, 1, 0, 16'h0A03, 16'h0000, 0, 0, 16'h0A01, 16'h0A02, 1, 1, 1);
    addv(0, 1, 1, 16'h0A04, 16'h0A05, 1, 0, 16'h0A03, 16'h0A04, 1, 1, 1);
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0A05, 16'h0000, 1, 0, 1);
    // Flush beats push and advance.
    addv(1, 1, 1, 16'hEEE1, 16'hEEE2, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    // Fill to 7, blocked push, ordered drain, pointer wrap.
    addv(0, 1, 1, 16'hB001, 16'hB002, 0, 0, 16'hB001, 16'hB002, 1, 1, 1);
    addv(0, 1, 1, 16'hB003, 16'hB004, 0, 0, 16'hB001, 16'hB002, 1, 1, 1);
    addv(0, 1, 1, 16'hB005, 16'hB006, 0, 0, 16'hB001, 16'hB002, 1, 1, 1);
    addv(0, 1, 0, 16'hB007, 16'h0000, 0, 0, 16'hB001, 16'hB002, 1, 1, 0);
    addv(0, 1, 1, 16'hC0DE, 16'hC0DF, 0, 0, 16'hB001, 16'hB002, 1, 1, 0);
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hB003, 16'hB004, 1, 1, 1);
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hB004, 16'hB005, 1, 1, 1);
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hB006, 16'hB007, 1, 1, 1);
    addv(0, 1, 1, 16'hD001, 16'hD002, 1, 0, 16'hD001, 16'hD002, 1, 1, 1);
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
    // Sustained dual throughput across the wrap point.
    addv(0, 1, 1, 16'hE001, 16'hE002, 0, 0, 16'hE001, 16'hE002, 1, 1, 1);
    addv(0, 1, 1, 16'hE003, 16'hE004, 1, 0, 16'hE003, 16'hE004, 1, 1, 1);
    addv(0, 1, 1, 16'hE005, 16'hE006, 1, 0, 16'hE005, 16'hE006, 1, 1, 1);
    addv(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);

    // Reset values, checked in reset and just after release.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk_all("reset_rel", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      flush = vecs[k].flush; wr_valid = vecs[k].wv; wr_two = vecs[k].two;
      wr_instr0 = vecs[k].i0; wr_instr1 = vecs[k].i1;
      advance = vecs[k].adv; issingleinstr = vecs[k].single;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", k), vecs[k].e1, vecs[k].e2, vecs[k].eh, vecs[k].ep, vecs[k].er);
    end

    // Asynchronous reset with five entries held, mid-cycle.
    push_cycle(1'b1, 16'hF001, 16'hF002);
    push_cycle(1'b1, 16'hF003, 16'hF004);
    push_cycle(1'b0, 16'hF005, 16'h0000);
    chk_all("pre_async", 16'hF001, 16'hF002, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    idle_inputs();
    #1;
    rst_n = 0;
    #1;
    chk_all("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk_all("post_async", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
